// File: rtl/core_pipe_fetch_buffer_pkg.sv
// Shared widths and length-code constants for the fetch buffer and its pre-decoder.
// Also holds the small helpers used to classify halfwords.
package core_pipe_fetch_buffer_pkg;

    localparam int XL           = 31;
    localparam int FD_IBUF_R    = 31;
    localparam int FD_ERR_R     = 1;
    localparam int HW_PER_FETCH = 4;

    localparam logic [1:0]  LEN32_CODE    = 2'b11;
    localparam logic [XL:0] PC_ALIGN_MASK = {{XL{1'b1}}, 1'b0};

    function automatic logic hw_is_32(input logic [15:0] hw);
        return (hw[1:0] == LEN32_CODE);
    endfunction

endpackage

// File: rtl/core_pipe_fetch_buffer_chk.sv
// Protocol checks on the decode-side eat handshake.
module core_pipe_fetch_buffer_chk (
    input logic       g_clk,
    input logic       g_resetn,
    input logic       s2_eat_2,
    input logic       s2_eat_4,
    input logic [1:0] eat_hw
);

    a_eat_exclusive: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(s2_eat_2 && s2_eat_4));

    a_eat2_matches: assert property (@(posedge g_clk) disable iff (!g_resetn)
        s2_eat_2 |-> (eat_hw == 2'd1));

    a_eat4_matches: assert property (@(posedge g_clk) disable iff (!g_resetn)
        s2_eat_4 |-> (eat_hw == 2'd2));

endmodule

// File: rtl/core_pipe_fetch_predecode.sv
// Combinational length pre-decode of the buffer head.
// A faulting head is always treated as 16-bit so a missing upper half cannot stall decode.
module core_pipe_fetch_predecode
    import core_pipe_fetch_buffer_pkg::*;
(
    input  logic [15:0] hw0,
    input  logic        err0,
    input  logic [3:0]  occ,
    output logic        s1_16bit,
    output logic        s1_32bit,
    output logic [1:0]  eat_hw
);

    // Classify the head halfword and report how many halfwords it occupies.
    always_comb begin
        s1_16bit = 1'b0;
        s1_32bit = 1'b0;
        eat_hw   = 2'd0;
        if (occ == 4'd0) begin
            s1_16bit = 1'b0;
            s1_32bit = 1'b0;
            eat_hw   = 2'd0;
        end else if (hw_is_32(hw0) && !err0) begin
            if (occ >= 4'd2) begin
                s1_32bit = 1'b1;
                eat_hw   = 2'd2;
            end else begin
                s1_32bit = 1'b0;
                eat_hw   = 2'd0;
            end
        end else begin
            s1_16bit = 1'b1;
            eat_hw   = 2'd1;
        end
    end

endmodule

// File: rtl/core_pipe_fetch_buffer.sv
// Halfword fetch queue and instruction aligner between instruction memory and decode.
// Presents one 16- or 32-bit instruction per cycle and retires what decode eats.
module core_pipe_fetch_buffer
    import core_pipe_fetch_buffer_pkg::*;
#(
    parameter int BUF_HW  = 8,
    parameter int FETCH_W = 64
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic                cf_req,
    input  logic [XL:0]         cf_target,
    input  logic                f_rsp_valid,
    output logic                f_rsp_ready,
    input  logic [FETCH_W-1:0]  f_rsp_data,
    input  logic                f_rsp_error,
    output logic                s1_16bit,
    output logic                s1_32bit,
    output logic [FD_IBUF_R:0]  s1_instr,
    output logic [XL:0]         s1_pc,
    output logic [FD_ERR_R:0]   s1_ferr,
    input  logic                s2_eat_2,
    input  logic                s2_eat_4
);

    logic [15:0]       hw_r   [BUF_HW];
    logic [BUF_HW-1:0] err_r;
    logic [3:0]        occ_r;
    logic [XL:0]       pc_r;
    logic [1:0]        drop_r;

    logic [15:0]       hw_n_s [BUF_HW];
    logic [BUF_HW-1:0] err_n_s;
    logic [3:0]        occ_n_s;
    logic [XL:0]       pc_n_s;
    logic [1:0]        drop_n_s;

    logic [15:0]       rsp_hw_s [HW_PER_FETCH];
    logic [3:0]        sh_idx_s [BUF_HW];
    logic [3:0]        rel_s    [BUF_HW];
    logic [1:0]        fetch_idx_s [BUF_HW];
    logic [BUF_HW-1:0] fill_sel_s;
    logic              accept_s;
    logic [3:0]        eaten_s;
    logic [3:0]        base_s;
    logic [3:0]        keep_s;
    logic              pd_16_s;
    logic              pd_32_s;
    logic [1:0]        pd_eat_hw_s;

    // Ready depends only on registered occupancy so eats never reach it combinationally.
    assign f_rsp_ready = (occ_r <= 4'd4);
    assign accept_s    = f_rsp_valid && f_rsp_ready;
    assign s1_pc       = pc_r;
    assign s1_16bit    = pd_16_s;
    assign s1_32bit    = pd_32_s;

    // Split the fetch response into halfwords and work out eat and fill amounts.
    always_comb begin
        for (int j = 0; j < HW_PER_FETCH; j++) begin
            rsp_hw_s[j] = f_rsp_data[16*j +: 16];
        end
        eaten_s = 4'd0;
        if (s2_eat_4) begin
            eaten_s = 4'd2;
        end else if (s2_eat_2) begin
            eaten_s = 4'd1;
        end else begin
            eaten_s = 4'd0;
        end
        base_s   = occ_r - eaten_s;
        keep_s   = 4'd4 - {2'b00, drop_r};
        occ_n_s  = base_s + (accept_s ? keep_s : 4'd0);
        pc_n_s   = pc_r + {{(XL-4){1'b0}}, eaten_s, 1'b0};
        drop_n_s = accept_s ? 2'b00 : drop_r;
    end

    // Shift out eaten halfwords, then append the kept part of an accepted response.
    always_comb begin
        for (int i = 0; i < BUF_HW; i++) begin
            sh_idx_s[i]    = 4'(i) + eaten_s;
            rel_s[i]       = 4'(i) - base_s;
            fill_sel_s[i]  = accept_s && (4'(i) >= base_s) && (rel_s[i] < keep_s);
            fetch_idx_s[i] = rel_s[i][1:0] + drop_r;
            if (fill_sel_s[i]) begin
                hw_n_s[i]  = rsp_hw_s[fetch_idx_s[i]];
                err_n_s[i] = f_rsp_error;
            end else if (!sh_idx_s[i][3]) begin
                hw_n_s[i]  = hw_r[sh_idx_s[i][2:0]];
                err_n_s[i] = err_r[sh_idx_s[i][2:0]];
            end else begin
                hw_n_s[i]  = 16'h0000;
                err_n_s[i] = 1'b0;
            end
        end
    end

    // Queue state; a control-flow change overrides any eat or fill in the same cycle.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < BUF_HW; i++) begin
                hw_r[i] <= 16'h0000;
            end
            err_r  <= '0;
            occ_r  <= 4'd0;
            pc_r   <= '0;
            drop_r <= 2'b00;
        end else if (cf_req) begin
            occ_r  <= 4'd0;
            pc_r   <= cf_target & PC_ALIGN_MASK;
            drop_r <= cf_target[2:1];
        end else begin
            hw_r   <= hw_n_s;
            err_r  <= err_n_s;
            occ_r  <= occ_n_s;
            pc_r   <= pc_n_s;
            drop_r <= drop_n_s;
        end
    end

    core_pipe_fetch_predecode u_predecode (
        .hw0      (hw_r[0]),
        .err0     (err_r[0]),
        .occ      (occ_r),
        .s1_16bit (pd_16_s),
        .s1_32bit (pd_32_s),
        .eat_hw   (pd_eat_hw_s)
    );

    // Assemble the presented instruction and its per-halfword fault flags.
    always_comb begin
        s1_instr = '0;
        s1_ferr  = '0;
        if (pd_32_s) begin
            s1_instr = {hw_r[1], hw_r[0]};
            s1_ferr  = {err_r[1], 1'b0};
        end else if (pd_16_s) begin
            s1_instr = {16'h0000, hw_r[0]};
            s1_ferr  = {1'b0, err_r[0]};
        end else begin
            s1_instr = '0;
            s1_ferr  = '0;
        end
    end

    core_pipe_fetch_buffer_chk u_chk (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .s2_eat_2 (s2_eat_2),
        .s2_eat_4 (s2_eat_4),
        .eat_hw   (pd_eat_hw_s)
    );

endmodule

// File: tb/tb_core_pipe_fetch_buffer.sv
// Scoreboard bench for core_pipe_fetch_buffer: expected instructions are queued as
// eats are issued and a negedge monitor compares them against the presented s1_* outputs.
module tb_core_pipe_fetch_buffer;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cf_req;
    logic [31:0] cf_target;
    logic        f_rsp_valid;
    logic        f_rsp_ready;
    logic [63:0] f_rsp_data;
    logic        f_rsp_error;
    logic        s1_16bit;
    logic        s1_32bit;
    logic [31:0] s1_instr;
    logic [31:0] s1_pc;
    logic [1:0]  s1_ferr;
    logic        s2_eat_2;
    logic        s2_eat_4;

    typedef struct packed {
        logic        is32;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  ferr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   acc_cnt;

    core_pipe_fetch_buffer dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .cf_req      (cf_req),
        .cf_target   (cf_target),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_ready (f_rsp_ready),
        .f_rsp_data  (f_rsp_data),
        .f_rsp_error (f_rsp_error),
        .s1_16bit    (s1_16bit),
        .s1_32bit    (s1_32bit),
        .s1_instr    (s1_instr),
        .s1_pc       (s1_pc),
        .s1_ferr     (s1_ferr),
        .s2_eat_2    (s2_eat_2),
        .s2_eat_4    (s2_eat_4)
    );

    // Free-running clock.
    always #5 g_clk = ~g_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every eat consumes one scoreboard entry, compared against what the DUT presents.
    always @(negedge g_clk) begin
        if (g_resetn === 1'b1 && (s2_eat_2 || s2_eat_4)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got eat with empty scoreboard, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_kind", 32'({s1_32bit, s1_16bit}), mon_e.is32 ? 32'd2 : 32'd1);
                check("sb_instr", s1_instr, mon_e.instr);
                check("sb_pc", s1_pc, mon_e.pc);
                check("sb_ferr", 32'(s1_ferr), 32'(mon_e.ferr));
            end
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic e);
        f_rsp_valid = 1'b1;
        f_rsp_data  = d;
        f_rsp_error = e;
        tick();
        f_rsp_valid = 1'b0;
        f_rsp_error = 1'b0;
    endtask

    task automatic flush(input logic [31:0] t);
        cf_req    = 1'b1;
        cf_target = t;
        tick();
        cf_req    = 1'b0;
    endtask

    task automatic eat(input logic four, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [1:0] ferr);
        exp_q.push_back('{four, instr, pc, ferr});
        if (four) s2_eat_4 = 1'b1;
        else      s2_eat_2 = 1'b1;
        tick();
        s2_eat_2 = 1'b0;
        s2_eat_4 = 1'b0;
    endtask

    task automatic check_empty(input string name);
        check(name, 32'({s1_32bit, s1_16bit}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'({s1_32bit, s1_16bit}), 32'd0);
        check({tag, "_instr"}, s1_instr, 32'h0000_0000);
        check({tag, "_pc"}, s1_pc, 32'h0000_0000);
        check({tag, "_ferr"}, 32'(s1_ferr), 32'd0);
        check({tag, "_ready"}, 32'(f_rsp_ready), 32'd1);
    endtask

    initial begin
        g_resetn    = 1'b0;
        cf_req      = 1'b0;
        cf_target   = 32'h0000_0000;
        f_rsp_valid = 1'b0;
        f_rsp_data  = 64'h0;
        f_rsp_error = 1'b0;
        s2_eat_2    = 1'b0;
        s2_eat_4    = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge g_clk);
        #2 g_resetn = 1'b1;
        tick();

        // 1: single response, 32-bit then two 16-bit instructions
        send(64'h0001_0002_0003_0413, 1'b0);
        check("t1_32bit", 32'(s1_32bit), 32'd1);
        eat(1'b1, 32'h0003_0413, 32'h0, 2'b00);
        check("t1_16bit", 32'(s1_16bit), 32'd1);
        check("t1_instr2", s1_instr, 32'h0000_0002);
        eat(1'b0, 32'h0000_0002, 32'h4, 2'b00);
        eat(1'b0, 32'h0000_0001, 32'h6, 2'b00);
        check_empty("t1_empty");
        check("t1_pc_end", s1_pc, 32'h8);

        // 2: mixed 32/16/16 packed in one response
        flush(32'h0);
        send(64'h8a02_4501_1234_0003, 1'b0);
        eat(1'b1, 32'h1234_0003, 32'h0, 2'b00);
        eat(1'b0, 32'h0000_4501, 32'h4, 2'b00);
        check("t2_ready", 32'(f_rsp_ready), 32'd1);
        eat(1'b0, 32'h0000_8a02, 32'h6, 2'b00);
        check_empty("t2_empty");

        // 3: straddling 32-bit instruction waits for its second halfword
        flush(32'h0000_0106);
        check("t3_pc", s1_pc, 32'h0000_0106);
        send(64'h0013_aaaa_bbbb_cccc, 1'b0);
        check_empty("t3_lone_head");
        send(64'h0001_0001_0001_00a3, 1'b0);
        eat(1'b1, 32'h00a3_0013, 32'h0000_0106, 2'b00);
        eat(1'b0, 32'h0000_0001, 32'h0000_010a, 2'b00);
        eat(1'b0, 32'h0000_0001, 32'h0000_010c, 2'b00);
        eat(1'b0, 32'h0000_0001, 32'h0000_010e, 2'b00);
        check_empty("t3_empty");

        // 4: flush wins over a same-cycle eat and response
        flush(32'h0000_0200);
        send(64'h0001_0001_0001_0001, 1'b0);
        exp_q.push_back('{1'b0, 32'h0000_0001, 32'h0000_0200, 2'b00});
        cf_req      = 1'b1;
        cf_target   = 32'h8000_0006;
        s2_eat_2    = 1'b1;
        f_rsp_valid = 1'b1;
        f_rsp_data  = 64'hffff_ffff_ffff_ffff;
        tick();
        cf_req      = 1'b0;
        s2_eat_2    = 1'b0;
        f_rsp_valid = 1'b0;
        check_empty("t4_flush_empty");
        check("t4_pc", s1_pc, 32'h8000_0006);
        send(64'h0005_1111_2222_3333, 1'b0);
        eat(1'b0, 32'h0000_0005, 32'h8000_0006, 2'b00);
        check_empty("t4_only_hw3");

        // 5: faulting responses
        flush(32'h0000_0300);
        send(64'h0001_0002_0003_0413, 1'b1);
        check("t5_16bit", 32'(s1_16bit), 32'd1);
        check("t5_ferr", 32'(s1_ferr), 32'd1);
        eat(1'b0, 32'h0000_0413, 32'h0000_0300, 2'b01);
        eat(1'b0, 32'h0000_0003, 32'h0000_0302, 2'b01);
        eat(1'b0, 32'h0000_0002, 32'h0000_0304, 2'b01);
        eat(1'b0, 32'h0000_0001, 32'h0000_0306, 2'b01);
        check_empty("t5_empty");
        flush(32'h0000_0406);
        send(64'h0013_0000_0000_0000, 1'b0);
        send(64'h0001_0001_0001_0001, 1'b1);
        eat(1'b1, 32'h0001_0013, 32'h0000_0406, 2'b10);
        flush(32'h0);
        check_empty("t5_flushed");

        // 6: back-pressure, then asynchronous reset mid-stream
        flush(32'h0000_0500);
        acc_cnt     = 0;
        f_rsp_valid = 1'b1;
        f_rsp_data  = 64'h0000_0003_0000_0003;
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            if (f_rsp_ready) acc_cnt++;
            tick();
        end
        f_rsp_valid = 1'b0;
        check("t6_accepted", 32'(acc_cnt), 32'd2);
        check("t6_ready_full", 32'(f_rsp_ready), 32'd0);
        eat(1'b1, 32'h0000_0003, 32'h0000_0500, 2'b00);
        check("t6_ready_occ6", 32'(f_rsp_ready), 32'd0);
        eat(1'b1, 32'h0000_0003, 32'h0000_0504, 2'b00);
        check("t6_ready_occ4", 32'(f_rsp_ready), 32'd1);
        check("t6_still_valid", 32'(s1_32bit), 32'd1);
        #2 g_resetn = 1'b0;
        #1;
        check_reset_outputs("t6_async");

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
